lsu: RTL and testbench
======================

# lsu

Load/store unit for the RV64 pipeline, directly downstream of the ALU. It takes the ALU result as the effective address, issues one naturally-aligned 64-bit-bus transaction to data memory over a req/gnt/rvalid handshake, then returns a sign- or zero-extended load result for writeback. Faults are reported to the trap logic. It stalls the upstream EX stage while a transaction is outstanding.

## Interface
- XLEN, 64: data and address width; only 64 is supported.
- TIMEOUT_CYCLES, 255: number of cycles in REQ+WAIT before a bus fault is raised; 0 disables the timeout.

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  EX stage presents a memory op
- o_ready  out  1  LSU can accept an op (state == IDLE)
- i_op  in  lsu_op_e  LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
- i_addr  in  64  effective address (ALU o_res)
- i_wdata  in  64  store data (rs2)
- i_rd  in  5  load destination register
- o_mem_req  out  1  bus request
- i_mem_gnt  in  1  request accepted
- o_mem_we  out  1  1 = store
- o_mem_addr  out  64  address with bits [2:0] = 0
- o_mem_be  out  8  byte enables
- o_mem_wdata  out  64  lane-replicated store data
- i_mem_rvalid  in  1  response valid (loads and stores)
- i_mem_rdata  in  64  load data
- i_mem_err  in  1  bus error, qualified by i_mem_rvalid
- o_done  out  1  one-cycle pulse per retired op
- o_wb_valid  out  1  one-cycle pulse: load result valid, rd != 0
- o_wb_rd  out  5  destination register
- o_wb_data  out  64  extended load data
- o_exc_valid  out  1  one-cycle pulse, coincident with o_done
- o_exc_cause  out  lsu_exc_e  LOAD_MISALIGN, STORE_MISALIGN, LOAD_FAULT, STORE_FAULT
- o_exc_addr  out  64  faulting i_addr (unaligned)

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: accept on i_valid && o_ready and capture op, addr, wdata, rd.
    - LSU_NONE or a trapped misaligned op goes to RESP.
    - Otherwise go to REQ.
  - REQ: o_mem_req = 1. Address, we, be and wdata are held stable until i_mem_gnt. Go to WAIT on gnt.
  - WAIT: on i_mem_rvalid, latch the result and go to RESP.
  - RESP: o_done = 1, plus o_wb_valid or o_exc_valid as applicable. Go to IDLE.
- Lane steering uses off = addr[2:0].
  - Byte enables: B = 1 << off, H = 3 << off, W = 0xF << off, D = 0xFF.
  - Store data: byte replicated ×8, half ×4, word ×2.
  - Load data: lane rdata[8*off +: size]. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- Load error (i_mem_rvalid with i_mem_err on a load): LOAD_FAULT, and o_wb_valid stays 0. The same condition on a store gives STORE_FAULT.
- Timeout: a counter is cleared on accept and increments in REQ and WAIT. When it reaches TIMEOUT_CYCLES, the op goes to RESP with a *_FAULT cause. A late rvalid is then ignored in IDLE.
- Loads with rd == 0 complete with o_done only, and o_wb_valid = 0.
- i_mem_rvalid and i_mem_gnt are ignored in any state where they are not expected.
- i_valid while o_ready = 0 is ignored. Upstream holds the op until it is accepted.

## Timing
- Reset values:
  - state IDLE and counter 0.
  - o_ready = 1.
  - All other outputs 0, and o_exc_cause = LOAD_MISALIGN (encoding 0).
- Asserting reset mid-transaction drops o_mem_req immediately (asynchronous). A response arriving after reset is ignored.
- Accept at cycle N gives o_mem_req at N+1. The minimum case is gnt at N+1 and rvalid at N+2, so o_done/o_wb_valid appear at N+3, with o_ready = 0 from N+1 to N+3.
- o_ready rises at N+4. Peak throughput is one op per 4 cycles.
- LSU_NONE or a misaligned trap: o_done (and o_exc_valid for the trap) at N+1, with no bus activity.
- o_wb_* and o_exc_* are registered and hold their value outside the pulse. Only the valid signals pulse.

## Configuration
- RV_LSU_MISALIGN_TRAP_EN defined: a misaligned access raises LOAD_MISALIGN or STORE_MISALIGN and issues no bus request. Misaligned means:
  - H with addr[0] set
  - W with addr[1:0] != 0
  - D with addr[2:0] != 0
- Undefined: the offset is forced to natural alignment (H clears bit 0, W clears bits 1:0, D uses offset 0). The access proceeds, and MISALIGN causes are never produced.

## Structure
- rv_pkg gains lsu_op_e, lsu_exc_e and lsu_state_e.
- Sub-module lsu_align is combinational lane steering: be generation, wdata replication, load extract/extend. It is instantiated once and unit-testable on its own.

## Test plan
- SB at 0x1003 with wdata 0xAB → o_mem_addr 0x1000, be 0x08, wdata 0xABABABABABABABAB, o_mem_we = 1, o_done at N+3, no o_wb_valid.
- LB at 0x2005, rdata 0x0000_8000_0000_0000 (lane 5 = 0x80), rd = 7 → o_wb_data 0xFFFFFFFFFFFFFF80 and o_wb_rd 7. Repeat with LBU → 0x80.
- LW at 0x3004, gnt held low for 5 cycles, then rvalid with i_mem_err = 1 → req and addr stable throughout, o_exc_valid with LOAD_FAULT, o_exc_addr 0x3004, o_wb_valid = 0.
- LD at 0x4002 → with RV_LSU_MISALIGN_TRAP_EN: LOAD_MISALIGN at N+1 and no o_mem_req. Without it: o_mem_addr 0x4000, be 0xFF.
- TIMEOUT_CYCLES = 4, SD with gnt but no rvalid → STORE_FAULT after 4 cycles in REQ+WAIT. A later rvalid in IDLE causes no output.
- Reset asserted in WAIT → o_mem_req and o_done are 0 immediately, o_ready = 1 after release, and the next LD completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the RV64 load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_XLEN = 64;
  localparam int unsigned LSU_BE_W = LSU_XLEN / 8;
  localparam int unsigned LSU_RD_W = 5;

  typedef enum logic [3:0] {
    LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  } lsu_op_e;

  typedef enum logic [1:0] {
    LOAD_MISALIGN, STORE_MISALIGN, LOAD_FAULT, STORE_FAULT
  } lsu_exc_e;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } lsu_state_e;

  // Bus request payload, held stable for the whole REQ phase
  typedef struct packed {
    logic                we;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_BE_W-1:0] be;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_mem_req_t;

  // Access size as log2(bytes); LSU_NONE reports doubleword
  function automatic logic [1:0] op_size(input lsu_op_e op);
    case (op)
      LB, LBU, SB: op_size = 2'd0;
      LH, LHU, SH: op_size = 2'd1;
      LW, LWU, SW: op_size = 2'd2;
      default:     op_size = 2'd3;
    endcase
  endfunction

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

  function automatic logic op_is_signed(input lsu_op_e op);
    return (op == LB) || (op == LH) || (op == LW);
  endfunction

  // Offset that violates natural alignment for the access size
  function automatic logic op_misaligned(input lsu_op_e op, input logic [2:0] off);
    case (op_size(op))
      2'd1:    op_misaligned = off[0];
      2'd2:    op_misaligned = (off[1:0] != 2'b00);
      2'd3:    op_misaligned = (op != LSU_NONE) && (off != 3'b000);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

  // Offset rounded down to natural alignment for the access size
  function automatic logic [2:0] op_nat_off(input lsu_op_e op, input logic [2:0] off);
    case (op_size(op))
      2'd0:    op_nat_off = off;
      2'd1:    op_nat_off = {off[2:1], 1'b0};
      2'd2:    op_nat_off = {off[2], 2'b00};
      default: op_nat_off = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: EX-side handshake, data-memory bus and writeback/trap outputs of the LSU.
interface lsu_if;
  import lsu_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  lsu_op_e              i_op;
  logic [LSU_XLEN-1:0]  i_addr;
  logic [LSU_XLEN-1:0]  i_wdata;
  logic [LSU_RD_W-1:0]  i_rd;

  logic                 o_mem_req;
  logic                 i_mem_gnt;
  logic                 o_mem_we;
  logic [LSU_XLEN-1:0]  o_mem_addr;
  logic [LSU_BE_W-1:0]  o_mem_be;
  logic [LSU_XLEN-1:0]  o_mem_wdata;
  logic                 i_mem_rvalid;
  logic [LSU_XLEN-1:0]  i_mem_rdata;
  logic                 i_mem_err;

  logic                 o_done;
  logic                 o_wb_valid;
  logic [LSU_RD_W-1:0]  o_wb_rd;
  logic [LSU_XLEN-1:0]  o_wb_data;
  logic                 o_exc_valid;
  lsu_exc_e             o_exc_cause;
  logic [LSU_XLEN-1:0]  o_exc_addr;

  // LSU side
  modport slave (
    input  i_valid, i_op, i_addr, i_wdata, i_rd,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output o_done, o_wb_valid, o_wb_rd, o_wb_data,
    output o_exc_valid, o_exc_cause, o_exc_addr
  );

  // Pipeline / memory side
  modport master (
    output i_valid, i_op, i_addr, i_wdata, i_rd,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  o_done, o_wb_valid, o_wb_rd, o_wb_data,
    input  o_exc_valid, o_exc_cause, o_exc_addr
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering - byte enables, store replication,
// load lane extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_e             op_i,
  input  logic [2:0]          off_i,
  input  logic [LSU_XLEN-1:0] wdata_i,
  input  logic [LSU_XLEN-1:0] rdata_i,
  output logic [LSU_BE_W-1:0] be_c_o,
  output logic [LSU_XLEN-1:0] wdata_c_o,
  output logic [LSU_XLEN-1:0] rdata_c_o
);

  logic [LSU_XLEN-1:0] lane;
  logic                sgn;

  // Steer by access size; offset is already legal for the size
  always_comb begin
    be_c_o    = '0;
    wdata_c_o = '0;
    rdata_c_o = '0;
    lane      = rdata_i >> {off_i, 3'b000};
    sgn       = op_is_signed(op_i);
    case (op_size(op_i))
      2'd0: begin
        be_c_o    = 8'h01 << off_i;
        wdata_c_o = {8{wdata_i[7:0]}};
        rdata_c_o = {{56{sgn & lane[7]}}, lane[7:0]};
      end
      2'd1: begin
        be_c_o    = 8'h03 << off_i;
        wdata_c_o = {4{wdata_i[15:0]}};
        rdata_c_o = {{48{sgn & lane[15]}}, lane[15:0]};
      end
      2'd2: begin
        be_c_o    = 8'h0F << off_i;
        wdata_c_o = {2{wdata_i[31:0]}};
        rdata_c_o = {{32{sgn & lane[31]}}, lane[31:0]};
      end
      default: begin
        be_c_o    = 8'hFF;
        wdata_c_o = wdata_i;
        rdata_c_o = lane;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV64 load/store unit. One naturally aligned 64-bit bus transaction per op
// over req/gnt/rvalid, extended load writeback, fault reporting, EX stall via o_ready.
// Define RV_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = LSU_XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic  i_clk,
  input logic  i_rst_n,
  lsu_if.slave io
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic       TO_EN     = (TIMEOUT_CYCLES != 0);

  lsu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  lsu_op_e             op_q, op_d;
  logic [2:0]          off_q, off_d;
  logic [LSU_RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  lsu_mem_req_t        req_q, req_d;
  logic                mem_req_q, mem_req_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                wb_valid_q, wb_valid_d;
  logic [LSU_RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic                exc_valid_q, exc_valid_d;
  lsu_exc_e            exc_cause_q, exc_cause_d;
  logic [XLEN-1:0]     exc_addr_q, exc_addr_d;

  logic                misalign;
  logic [2:0]          eff_off;
  logic                timeout_hit;
  logic                fault;

  lsu_op_e             al_op;
  logic [2:0]          al_off;
  logic [LSU_BE_W-1:0] al_be;
  logic [LSU_XLEN-1:0] al_wdata;
  logic [LSU_XLEN-1:0] al_rdata;

`ifdef RV_LSU_MISALIGN_TRAP_EN
  assign misalign = op_misaligned(io.i_op, io.i_addr[2:0]);
  assign eff_off  = io.i_addr[2:0];
`else
  assign misalign = 1'b0;
  assign eff_off  = op_nat_off(io.i_op, io.i_addr[2:0]);
`endif

  // Single steering instance: incoming op while idle, captured op once in flight
  assign al_op  = (state_q == IDLE) ? io.i_op : op_q;
  assign al_off = (state_q == IDLE) ? eff_off : off_q;

  lsu_align u_align (
    .op_i      (al_op),
    .off_i     (al_off),
    .wdata_i   (io.i_wdata),
    .rdata_i   (io.i_mem_rdata),
    .be_c_o    (al_be),
    .wdata_c_o (al_wdata),
    .rdata_c_o (al_rdata)
  );

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Next state, capture and registered-output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    req_d       = req_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    fault       = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.i_valid) begin
          op_d   = io.i_op;
          off_d  = eff_off;
          rd_d   = io.i_rd;
          addr_d = io.i_addr;
          cnt_d  = '0;
          if (io.i_op == LSU_NONE) begin
            state_d = RESP;
          end else if (misalign) begin
            state_d     = RESP;
            exc_valid_d = 1'b1;
            exc_cause_d = op_is_store(io.i_op) ? STORE_MISALIGN : LOAD_MISALIGN;
            exc_addr_d  = io.i_addr;
          end else begin
            state_d     = REQ;
            req_d.we    = op_is_store(io.i_op);
            req_d.addr  = {io.i_addr[XLEN-1:3], 3'b000};
            req_d.be    = al_be;
            req_d.wdata = al_wdata;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          fault = 1'b1;
        end else if (io.i_mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (io.i_mem_rvalid) begin
          state_d = RESP;
          if (io.i_mem_err) begin
            fault = 1'b1;
          end else if (!op_is_store(op_q) && (rd_q != '0)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = al_rdata;
          end
        end else if (timeout_hit) begin
          fault = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fault) begin
      state_d     = RESP;
      exc_valid_d = 1'b1;
      exc_cause_d = op_is_store(op_q) ? STORE_FAULT : LOAD_FAULT;
      exc_addr_d  = addr_q;
    end

    ready_d   = (state_d == IDLE);
    mem_req_d = (state_d == REQ);
    done_d    = (state_d == RESP);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= LSU_NONE;
      off_q       <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      req_q       <= '0;
      mem_req_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= LOAD_MISALIGN;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      mem_req_q   <= mem_req_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign io.o_ready     = ready_q;
  assign io.o_mem_req   = mem_req_q;
  assign io.o_mem_we    = req_q.we;
  assign io.o_mem_addr  = req_q.addr;
  assign io.o_mem_be    = req_q.be;
  assign io.o_mem_wdata = req_q.wdata;
  assign io.o_done      = done_q;
  assign io.o_wb_valid  = wb_valid_q;
  assign io.o_wb_rd     = wb_rd_q;
  assign io.o_wb_data   = wb_data_q;
  assign io.o_exc_valid = exc_valid_q;
  assign io.o_exc_cause = exc_cause_q;
  assign io.o_exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-arithmetic reference model.
module tb_lsu;
  import lsu_pkg::*;

`ifdef RV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [63:0] last_wbd;
  logic [4:0]  last_rd;
  lsu_exc_e    last_cause;
  logic [63:0] last_eaddr;

  lsu_if bus ();
  lsu_if bus2 ();

  lsu dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (bus)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic int bytes_of(input lsu_op_e op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, LWU, SW: return 4;
      default:     return 8;
    endcase
  endfunction

  // One op end to end, expectations derived from byte arithmetic
  task automatic run_op(input lsu_op_e op, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                        input logic [63:0] rdata, input logic err);
    int nb, off;
    bit store, load, sgn, mis, wb;
    logic [63:0] mask, e_addr, e_wd, e_ld;
    logic [7:0] e_be;
    nb    = bytes_of(op);
    store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    load  = (op != LSU_NONE) && !store;
    sgn   = (op == LB) || (op == LH) || (op == LW);
    off   = int'(addr[2:0]);
    mis   = TRAP_EN && (op != LSU_NONE) && ((off % nb) != 0);
    if (!TRAP_EN) off = (off / nb) * nb;
    mask   = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    e_addr = addr & ~64'h7;
    e_be   = 8'(((1 << nb) - 1) << off);
    e_wd   = '0;
    for (int i = 0; i < 8 / nb; i++) e_wd |= (wdata & mask) << (8 * nb * i);
    e_ld = (rdata >> (8 * off)) & mask;
    if (sgn && e_ld[8 * nb - 1]) e_ld |= ~mask;

    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    bus.i_rd    = rd;
    chk("ready_idle", bus.o_ready, 1'b1);
    step();
    bus.i_valid = 1'b0;
    bus.i_addr  = {$urandom, $urandom};
    bus.i_wdata = {$urandom, $urandom};
    bus.i_rd    = 5'($urandom);

    if (op == LSU_NONE || mis) begin
      chk("short_done", bus.o_done, 1'b1);
      chk("short_no_req", bus.o_mem_req, 1'b0);
      chk("short_no_wb", bus.o_wb_valid, 1'b0);
      chk("short_exc_valid", bus.o_exc_valid, mis);
      if (mis) begin
        last_cause = store ? STORE_MISALIGN : LOAD_MISALIGN;
        last_eaddr = addr;
      end
    end else begin
      chk("busy_ready_low", bus.o_ready, 1'b0);
      for (int g = 0; g < gnt_dly; g++) begin
        chk("req_held", bus.o_mem_req, 1'b1);
        chk("addr_held", bus.o_mem_addr, e_addr);
        chk("be_held", bus.o_mem_be, e_be);
        step();
      end
      bus.i_mem_gnt = 1'b1;
      chk("req_at_gnt", bus.o_mem_req, 1'b1);
      chk("mem_addr", bus.o_mem_addr, e_addr);
      chk("mem_be", bus.o_mem_be, e_be);
      chk("mem_we", bus.o_mem_we, store);
      if (store) chk("mem_wdata", bus.o_mem_wdata, e_wd);
      step();
      bus.i_mem_gnt = 1'b0;
      chk("wait_req_low", bus.o_mem_req, 1'b0);
      chk("wait_no_done", bus.o_done, 1'b0);
      for (int r = 0; r < rv_dly; r++) step();
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = rdata;
      bus.i_mem_err    = err;
      step();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_err    = 1'b0;
      bus.i_mem_rdata  = {$urandom, $urandom};
      wb = load && !err && (rd != 5'd0);
      chk("resp_done", bus.o_done, 1'b1);
      chk("resp_wb_valid", bus.o_wb_valid, wb);
      chk("resp_exc_valid", bus.o_exc_valid, err);
      if (wb) begin
        last_wbd = e_ld;
        last_rd  = rd;
      end
      if (err) begin
        last_cause = store ? STORE_FAULT : LOAD_FAULT;
        last_eaddr = addr;
      end
    end
    chk("wb_data", bus.o_wb_data, last_wbd);
    chk("wb_rd", bus.o_wb_rd, last_rd);
    chk("exc_cause", bus.o_exc_cause, last_cause);
    chk("exc_addr", bus.o_exc_addr, last_eaddr);
    step();
    chk("after_done_low", bus.o_done, 1'b0);
    chk("after_wb_low", bus.o_wb_valid, 1'b0);
    chk("after_exc_low", bus.o_exc_valid, 1'b0);
    chk("after_ready", bus.o_ready, 1'b1);
    chk("hold_wb_data", bus.o_wb_data, last_wbd);
    chk("hold_exc_cause", bus.o_exc_cause, last_cause);
    chk("hold_exc_addr", bus.o_exc_addr, last_eaddr);
  endtask

  // Reset while an LD is in REQ or WAIT, then a stale response
  task automatic reset_mid(input bit in_wait);
    bus.i_valid = 1'b1;
    bus.i_op    = LD;
    bus.i_addr  = 64'h7000;
    bus.i_rd    = 5'd9;
    step();
    bus.i_valid = 1'b0;
    if (in_wait) begin
      bus.i_mem_gnt = 1'b1;
      step();
      bus.i_mem_gnt = 1'b0;
    end
    chk("rst_pre_req", bus.o_mem_req, !in_wait);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", bus.o_mem_req, 1'b0);
    chk("rst_done_low", bus.o_done, 1'b0);
    chk("rst_ready", bus.o_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    last_wbd   = '0;
    last_rd    = '0;
    last_cause = LOAD_MISALIGN;
    last_eaddr = '0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hDEAD_BEEF_0000_1111;
    step();
    bus.i_mem_rvalid = 1'b0;
    chk("stale_no_done", bus.o_done, 1'b0);
    chk("stale_no_wb", bus.o_wb_valid, 1'b0);
    chk("stale_ready", bus.o_ready, 1'b1);
    run_op(LD, 64'h7008, 64'h0, 5'd9, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_wbd    = '0;
    last_rd     = '0;
    last_cause  = LOAD_MISALIGN;
    last_eaddr  = '0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;  bus.i_op = LSU_NONE; bus.i_addr = '0; bus.i_wdata = '0; bus.i_rd = '0;
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0; bus.i_mem_err = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_op = LSU_NONE; bus2.i_addr = '0; bus2.i_wdata = '0; bus2.i_rd = '0;
    bus2.i_mem_gnt = 1'b0; bus2.i_mem_rvalid = 1'b0; bus2.i_mem_rdata = '0; bus2.i_mem_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.o_ready, 1'b1);
    chk("rst_mem_req", bus.o_mem_req, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_wb_valid", bus.o_wb_valid, 1'b0);
    chk("rst_exc_valid", bus.o_exc_valid, 1'b0);
    chk("rst_exc_cause", bus.o_exc_cause, 64'd0);
    chk("rst_wb_data", bus.o_wb_data, 64'd0);
    chk("rst_mem_be", bus.o_mem_be, 64'd0);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_op(SB, 64'h1003, 64'hAB, 5'd0, 0, 0, 64'h0, 1'b0);
    run_op(LB, 64'h2005, 64'h55AA, 5'd7, 0, 0, 64'h0000_8000_0000_0000, 1'b0);
    run_op(LBU, 64'h2005, 64'h0, 5'd7, 0, 0, 64'h0000_8000_0000_0000, 1'b0);
    chk("lbu_value", bus.o_wb_data, 64'h80);
    run_op(LW, 64'h3004, 64'h0, 5'd3, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("lw_fault_cause", bus.o_exc_cause, LOAD_FAULT);
    chk("lw_fault_addr", bus.o_exc_addr, 64'h3004);
    run_op(LD, 64'h4002, 64'h0, 5'd4, 0, 1, 64'hFEDC_BA98_7654_3210, 1'b0);
    run_op(LSU_NONE, 64'h5000, 64'h0, 5'd1, 0, 0, 64'h0, 1'b0);
    run_op(LHU, 64'h6006, 64'h0, 5'd0, 1, 2, 64'h8001_0000_0000_0000, 1'b0);
    run_op(SW, 64'h6004, 64'h1234_5678_9ABC_DEF0, 5'd0, 0, 0, 64'h0, 1'b1);

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      lsu_op_e     op;
      logic [4:0]  rd;
      op = lsu_op_e'(4'($urandom_range(0, 11)));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_op(op, {$urandom, $urandom}, {$urandom, $urandom}, rd,
             $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
             ($urandom_range(0, 7) == 0));
    end

    reset_mid(1'b1);
    reset_mid(1'b0);

    // Timeout: SD granted, no response
    bus2.i_valid = 1'b1;
    bus2.i_op    = SD;
    bus2.i_addr  = 64'h5008;
    bus2.i_wdata = 64'h1122_3344_5566_7788;
    chk("to_ready", bus2.o_ready, 1'b1);
    step();
    bus2.i_valid   = 1'b0;
    bus2.i_mem_gnt = 1'b1;
    chk("to_sd_req", bus2.o_mem_req, 1'b1);
    step();
    bus2.i_mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("to_sd_pending", bus2.o_done, 1'b0);
      step();
    end
    chk("to_sd_done", bus2.o_done, 1'b1);
    chk("to_sd_exc", bus2.o_exc_valid, 1'b1);
    chk("to_sd_cause", bus2.o_exc_cause, STORE_FAULT);
    chk("to_sd_addr", bus2.o_exc_addr, 64'h5008);
    step();
    chk("to_sd_ready", bus2.o_ready, 1'b1);
    bus2.i_mem_rvalid = 1'b1;
    bus2.i_mem_err    = 1'b1;
    step();
    bus2.i_mem_rvalid = 1'b0;
    bus2.i_mem_err    = 1'b0;
    chk("late_no_done", bus2.o_done, 1'b0);
    chk("late_no_exc", bus2.o_exc_valid, 1'b0);
    chk("late_no_req", bus2.o_mem_req, 1'b0);
    chk("late_ready", bus2.o_ready, 1'b1);

    // Timeout: LW never granted
    bus2.i_valid = 1'b1;
    bus2.i_op    = LW;
    bus2.i_addr  = 64'h6004;
    bus2.i_rd    = 5'd2;
    step();
    bus2.i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_lw_req", bus2.o_mem_req, 1'b1);
      step();
    end
    chk("to_lw_done", bus2.o_done, 1'b1);
    chk("to_lw_req_low", bus2.o_mem_req, 1'b0);
    chk("to_lw_cause", bus2.o_exc_cause, LOAD_FAULT);
    chk("to_lw_no_wb", bus2.o_wb_valid, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
